// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the processor step controller and its key debouncers.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT_PRESS,
        WAIT_RELEASE,
        HALT
    } step_state_t;

    localparam logic [5:0] IN_OPCODE  = 6'b011110;
    localparam logic [5:0] HLT_OPCODE = 6'b011111;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low push button and accepts a new level only after it has
// been stable for DEB_CYCLES consecutive clocks; emits one-cycle press/release events.
module key_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_evt,
    output logic release_evt
);

    localparam int CW = count_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          sampled_pressed;
    logic [CW-1:0] stable_cnt;

    assign sampled_pressed = ~sync_q2;

    // Synchroniser flops reset to the released (high) pin level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_cnt  <= '0;
            level       <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            if (sampled_pressed == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt  <= '0;
                level       <= sampled_pressed;
                press_evt   <= sampled_pressed;
                release_evt <= ~sampled_pressed;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_step_controller.sv
// Generates the processor step enable: free-running divider, stalls for operator input,
// halts on HLT, and debounces the interruption key. `define STEP_MODE_EN adds step_mode.
module cpu_step_controller #(
    parameter int         DIV        = 25000000,
    parameter int         DEB_CYCLES = 500000,
    parameter logic [5:0] IN_OPCODE  = cpu_ctrl_pkg::IN_OPCODE,
    parameter logic [5:0] HLT_OPCODE = cpu_ctrl_pkg::HLT_OPCODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter,
    input  logic       interruption,
    input  logic [5:0] opcode,
`ifdef STEP_MODE_EN
    input  logic       step_mode,
`endif
    output logic       clk_en,
    output logic       int_pulse,
    output logic       waiting_input,
    output logic       halted
);

    import cpu_ctrl_pkg::*;

    localparam int DW = count_width(DIV);
    localparam logic [DW-1:0] TICK_COUNT = DW'(DIV - 1);

    step_state_t   state;
    step_state_t   state_next;
    logic [DW-1:0] count;
    logic [DW-1:0] count_next;
    logic          tick;
    logic          stall_op;
    logic          clk_en_next;

    logic enter_level;
    logic enter_press;
    logic enter_release;
    logic int_level;
    logic int_press;
    logic int_release;
    logic unused_key_status;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_enter_debounce (
        .clock       (clock),
        .reset       (reset),
        .key_n       (enter),
        .level       (enter_level),
        .press_evt   (enter_press),
        .release_evt (enter_release)
    );

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_int_debounce (
        .clock       (clock),
        .reset       (reset),
        .key_n       (interruption),
        .level       (int_level),
        .press_evt   (int_press),
        .release_evt (int_release)
    );

    assign unused_key_status = enter_level ^ int_level ^ int_release;

    assign tick = (count == TICK_COUNT);

    // Single-stepping treats every RUN instruction like an input instruction.
`ifdef STEP_MODE_EN
    assign stall_op = (opcode == IN_OPCODE) || step_mode;
`else
    assign stall_op = (opcode == IN_OPCODE);
`endif

    always_comb begin
        state_next  = state;
        count_next  = '0;
        clk_en_next = 1'b0;
        case (state)
            RUN: begin
                if (tick) begin
                    if (opcode == HLT_OPCODE) begin
                        state_next = HALT;
                    end else if (stall_op) begin
                        state_next = WAIT_PRESS;
                    end else begin
                        clk_en_next = 1'b1;
                    end
                end else begin
                    count_next = count + 1'b1;
                end
            end
            WAIT_PRESS: begin
                if (enter_press) begin
                    clk_en_next = 1'b1;
                    state_next  = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (enter_release) begin
                    state_next = RUN;
                end
            end
            HALT: begin
                if (int_press) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Status outputs follow the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            count         <= '0;
            clk_en        <= 1'b0;
            int_pulse     <= 1'b0;
            waiting_input <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            clk_en        <= clk_en_next;
            int_pulse     <= int_press;
            waiting_input <= (state_next == WAIT_PRESS) || (state_next == WAIT_RELEASE);
            halted        <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller: directed vector table, async-reset and
// step-mode sequences, then randomised keys/opcodes against a behavioural model.
module tb_cpu_step_controller;

    localparam int DIV  = 4;
    localparam int DEB  = 3;
    localparam int HIST = DEB + 2;
    localparam logic [5:0] OP_IN  = 6'b011110;
    localparam logic [5:0] OP_HLT = 6'b011111;

    localparam int M_FREE    = 0;
    localparam int M_STALL_P = 1;
    localparam int M_STALL_R = 2;
    localparam int M_HALTED  = 3;

    logic       clock;
    logic       reset;
    logic       enter;
    logic       interruption;
    logic [5:0] opcode;
    logic       step_mode;
    logic       clk_en;
    logic       int_pulse;
    logic       waiting_input;
    logic       halted;

    int checks;
    int errors;
    int clkSeen;
    int intSeen;

    cpu_step_controller #(
        .DIV        (DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enter         (enter),
        .interruption  (interruption),
        .opcode        (opcode),
`ifdef STEP_MODE_EN
        .step_mode     (step_mode),
`endif
        .clk_en        (clk_en),
        .int_pulse     (int_pulse),
        .waiting_input (waiting_input),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: keys accepted once the last DEB synchronised samples agree,
    // steps happen every DIV cycles of uninterrupted running.
    logic [HIST-1:0] eHist;
    logic [HIST-1:0] iHist;
    logic eAcc, iAcc, ePressEvt, eRelEvt, iPressEvt;
    int   mode;
    int   runAge;
    logic mClkEn, mIntPulse;

    function automatic void modelReset();
        eHist = '0; iHist = '0;
        eAcc = 1'b0; iAcc = 1'b0;
        ePressEvt = 1'b0; eRelEvt = 1'b0; iPressEvt = 1'b0;
        mode = M_FREE; runAge = 0;
        mClkEn = 1'b0; mIntPulse = 1'b0;
    endfunction

    function automatic void modelEdge();
        logic stepSel;
        if (!reset) begin
            modelReset();
            return;
        end
        stepSel = 1'b0;
`ifdef STEP_MODE_EN
        stepSel = step_mode;
`endif
        mClkEn    = 1'b0;
        mIntPulse = iPressEvt;
        case (mode)
            M_FREE: begin
                runAge++;
                if (runAge % DIV == 0) begin
                    if (opcode == OP_HLT) mode = M_HALTED;
                    else if (opcode == OP_IN || stepSel) mode = M_STALL_P;
                    else mClkEn = 1'b1;
                end
            end
            M_STALL_P: if (ePressEvt) begin mClkEn = 1'b1; mode = M_STALL_R; end
            M_STALL_R: if (eRelEvt) begin mode = M_FREE; runAge = 0; end
            default:   if (iPressEvt) begin mode = M_FREE; runAge = 0; end
        endcase
        eHist = {eHist[HIST-2:0], ~enter};
        iHist = {iHist[HIST-2:0], ~interruption};
        ePressEvt = 1'b0; eRelEvt = 1'b0; iPressEvt = 1'b0;
        if (eHist[HIST-1:2] == {DEB{~eAcc}}) begin
            eAcc = ~eAcc; ePressEvt = eAcc; eRelEvt = ~eAcc;
        end
        if (iHist[HIST-1:2] == {DEB{~iAcc}}) begin
            iAcc = ~iAcc; iPressEvt = iAcc;
        end
    endfunction

    task automatic checkOutput(input string tag);
        logic [3:0] got, want;
        got  = {clk_en, int_pulse, waiting_input, halted};
        want = {mClkEn, mIntPulse, (mode == M_STALL_P || mode == M_STALL_R), (mode == M_HALTED)};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: outputs {clk_en,int_pulse,waiting,halted} got=%b want=%b at %0t",
                     tag, got, want, $time);
        end
    endtask

    task automatic compareInt(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got=%0d want=%0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic stepCycle(input string tag);
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        clkSeen += int'(clk_en);
        intSeen += int'(int_pulse);
        checkOutput(tag);
    endtask

    task automatic waitForWaiting(input string tag, input int budget);
        int n = 0;
        while (waiting_input !== 1'b1 && n < budget) begin
            stepCycle(tag);
            n++;
        end
        compareInt({tag, "_reached"}, int'(waiting_input === 1'b1), 1);
    endtask

    typedef struct {
        logic       enterN;
        logic       intN;
        logic [5:0] op;
        int         cycles;
        int         expClk;
        int         expInt;
        logic       expWait;
        logic       expHalt;
        string      name;
    } vec_t;

    vec_t vecs[17];

    task automatic applyStimulus(input vec_t v);
        enter        = v.enterN;
        interruption = v.intN;
        opcode       = v.op;
        clkSeen = 0;
        intSeen = 0;
        repeat (v.cycles) stepCycle(v.name);
        compareInt({v.name, "_clk_en_count"}, clkSeen, v.expClk);
        compareInt({v.name, "_int_pulse_count"}, intSeen, v.expInt);
        compareInt({v.name, "_waiting_input"}, int'(waiting_input), int'(v.expWait));
        compareInt({v.name, "_halted"}, int'(halted), int'(v.expHalt));
    endtask

    initial begin
        int eHold;
        int iHold;
        int r;
        checks = 0;
        errors = 0;
        clkSeen = 0;
        intSeen = 0;

        vecs[0]  = '{1'b1, 1'b1, 6'd0,   12,  3, 0, 1'b0, 1'b0, "free_run"};
        vecs[1]  = '{1'b1, 1'b1, OP_IN,   4,  0, 0, 1'b1, 1'b0, "in_tick"};
        vecs[2]  = '{1'b0, 1'b1, OP_IN,   2,  0, 0, 1'b1, 1'b0, "enter_glitch"};
        vecs[3]  = '{1'b1, 1'b1, OP_IN,   6,  0, 0, 1'b1, 1'b0, "glitch_gap"};
        vecs[4]  = '{1'b0, 1'b1, OP_IN,   6,  1, 0, 1'b1, 1'b0, "enter_press"};
        vecs[5]  = '{1'b1, 1'b1, 6'd0,    9,  0, 0, 1'b0, 1'b0, "enter_release"};
        vecs[6]  = '{1'b1, 1'b1, 6'd0,    1,  1, 0, 1'b0, 1'b0, "resume_step"};
        vecs[7]  = '{1'b1, 1'b1, OP_HLT,  4,  0, 0, 1'b0, 1'b1, "hlt_tick"};
        vecs[8]  = '{1'b1, 1'b1, 6'd0,  100,  0, 0, 1'b0, 1'b1, "halt_quiet"};
        vecs[9]  = '{1'b1, 1'b0, 6'd0,    5,  0, 0, 1'b0, 1'b1, "int_debouncing"};
        vecs[10] = '{1'b1, 1'b1, 6'd0,    1,  0, 1, 1'b0, 1'b0, "int_wake"};
        vecs[11] = '{1'b1, 1'b1, 6'd0,    3,  0, 0, 1'b0, 1'b0, "restart_gap"};
        vecs[12] = '{1'b1, 1'b1, 6'd0,    1,  1, 0, 1'b0, 1'b0, "restart_step"};
        vecs[13] = '{1'b0, 1'b1, 6'd0,    8,  2, 0, 1'b0, 1'b0, "enter_in_run"};
        vecs[14] = '{1'b1, 1'b1, 6'd0,    8,  2, 0, 1'b0, 1'b0, "enter_up_run"};
        vecs[15] = '{1'b1, 1'b0, 6'd0,    8,  2, 1, 1'b0, 1'b0, "int_in_run"};
        vecs[16] = '{1'b1, 1'b1, 6'd0,    4,  1, 0, 1'b0, 1'b0, "int_up_run"};

        reset = 1'b0; enter = 1'b1; interruption = 1'b1; opcode = 6'd0; step_mode = 1'b0;
        modelReset();
        #1;
        compareInt("reset_state", int'({clk_en, int_pulse, waiting_input, halted}), 0);
        repeat (2) stepCycle("reset_hold");
        reset = 1'b1;

        for (int i = 0; i < 17; i++) applyStimulus(vecs[i]);

        // Asynchronous reset while stalled waiting for the enter key release.
        opcode = OP_IN; enter = 1'b1; interruption = 1'b1;
        waitForWaiting("stall_for_reset", 20);
        enter = 1'b0;
        clkSeen = 0;
        repeat (6) stepCycle("stall_press");
        compareInt("stall_press_clk_en_count", clkSeen, 1);
        compareInt("stall_press_waiting", int'(waiting_input), 1);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        compareInt("async_reset_outputs", int'({clk_en, int_pulse, waiting_input, halted}), 0);
        checkOutput("async_reset_model");
        repeat (2) stepCycle("mid_reset");
        reset = 1'b1; enter = 1'b1; opcode = 6'd0;
        clkSeen = 0;
        repeat (4) stepCycle("after_reset");
        compareInt("after_reset_clk_en_count", clkSeen, 1);
        compareInt("after_reset_waiting", int'(waiting_input), 0);

        // Random keys and opcodes against the model.
        eHold = 0;
        iHold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (eHold == 0) begin
                enter = 1'($urandom_range(0, 1));
                eHold = int'($urandom_range(1, 8));
            end
            if (iHold == 0) begin
                interruption = ($urandom_range(0, 2) != 0);
                iHold = int'($urandom_range(1, 8));
            end
            eHold--;
            iHold--;
            r = int'($urandom_range(0, 15));
            if (r < 2) opcode = OP_IN;
            else if (r == 2) opcode = OP_HLT;
            else opcode = 6'($urandom_range(0, 63));
            stepCycle("random");
        end

`ifdef STEP_MODE_EN
        reset = 1'b0; enter = 1'b1; interruption = 1'b1; opcode = 6'd0;
        repeat (2) stepCycle("step_reset");
        reset = 1'b1;
        step_mode = 1'b1;
        clkSeen = 0;
        for (int p = 0; p < 3; p++) begin
            waitForWaiting("step_wait", 40);
            enter = 1'b0;
            repeat (6) stepCycle("step_press");
            enter = 1'b1;
            repeat (6) stepCycle("step_release");
        end
        repeat (10) stepCycle("step_idle");
        compareInt("step_mode_clk_en_count", clkSeen, 3);
        compareInt("step_mode_waiting", int'(waiting_input), 1);
        step_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
